fwrisc_dbus_sram: RTL

Responder end of the fwrisc data interface (`dvalid`/`daddr`/`dwrite`/`dwdata`/`dwstb` → `drdata`/`dready`). It serves the core's load/store requests from an internal word-organised SRAM with byte-lane write strobes and a parameterisable wait-state count. It also decodes one memory-mapped `tohost` register and flags out-of-range accesses. It sits between the core's data port and the testbench or SoC top, replacing a behavioural memory model.

---
 rtl/fwrisc_dbus_sram.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fwrisc_dbus_sram.sv
// Data-bus responder for the fwrisc core: word SRAM with byte strobes, a tohost
// register, out-of-range detection and a fixed number of wait states per access.
module fwrisc_dbus_sram #(
  parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
  parameter int          MEM_WORDS   = 4096,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'h2000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic        dwrite,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  output logic [31:0] drdata,
  output logic        dready,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic        bus_err
);

  localparam int          IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit          NO_WAIT   = (WAIT_STATES == 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [29:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstb;
  logic [31:0] mem [MEM_WORDS];

  logic [29:0]      cur_addr;
  logic             cur_write;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_wstb;
  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             ram_hit;
  logic             tohost_hit;
  logic             go_resp;
  logic             unused;

  assign unused = ^daddr[1:0];

  // With no wait states the commit happens on the acceptance edge, so decode the live request
  always_comb begin
    if (state == ST_IDLE) begin
      cur_addr  = daddr[31:2];
      cur_write = dwrite;
      cur_wdata = dwdata;
      cur_wstb  = dwstb;
    end else begin
      cur_addr  = req_addr;
      cur_write = req_write;
      cur_wdata = req_wdata;
      cur_wstb  = req_wstb;
    end
  end

  assign offset     = {cur_addr, 2'b00} - MEM_BASE;
  assign ram_hit    = {1'b0, offset} < MEM_BYTES;
  assign idx        = offset[IDX_W+1:2];
  assign tohost_hit = (cur_addr == TOHOST_ADDR[31:2]);

  // Edge on which the FSM enters RESP: the single commit point of an access
  always_comb begin
    case (state)
      ST_IDLE: go_resp = dvalid && NO_WAIT;
      ST_WAIT: go_resp = (cnt == 4'd0);
      default: go_resp = 1'b0;
    endcase
  end

  // SRAM array; deliberately not reset so contents survive a core reset
  always_ff @(posedge clock) begin
    if (go_resp && !reset && cur_write && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_wstb[i]) begin
          mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  // Request FSM, wait counter and registered response outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      req_addr     <= 30'd0;
      req_write    <= 1'b0;
      req_wdata    <= 32'd0;
      req_wstb     <= 4'd0;
      dready       <= 1'b0;
      drdata       <= 32'd0;
      tohost_valid <= 1'b0;
      tohost_data  <= 32'd0;
      bus_err      <= 1'b0;
    end else begin
      dready       <= 1'b0;
      drdata       <= 32'd0;
      tohost_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dvalid) begin
            req_addr  <= daddr[31:2];
            req_write <= dwrite;
            req_wdata <= dwdata;
            req_wstb  <= dwstb;
            if (NO_WAIT) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (go_resp) begin
        dready <= 1'b1;
        if (!cur_write) begin
          if (ram_hit) begin
            drdata <= mem[idx];
          end else if (tohost_hit) begin
            drdata <= tohost_data;
          end else begin
            drdata <= 32'd0;
          end
        end
        if (cur_write && !ram_hit && tohost_hit) begin
          tohost_data  <= cur_wdata;
          tohost_valid <= 1'b1;
        end
        if (!ram_hit && !tohost_hit) begin
          bus_err <= 1'b1;
        end
      end
    end
  end

endmodule
